dtw_ref_loader: RTL and testbench
=================================

Name: dtw_ref_loader

Overview:
Writer side of the DTW reference memory. It drains packed reference samples from the shared source FIFO and writes them sequentially into the reference memory that dtw_core reads through addr_ref/dataout_ref. When the load completes it raises ref_load_done, which gates dtw_core's query mode. It also posts one status word to the sink FIFO so the host can confirm the load. It is active only when op_mode = 1 (MODE_LOAD_REF).

Parameters:
WIDTH, 16, reference sample width; two samples are packed per 32-bit FIFO word.
AXIS_WIDTH, 32, width of ref_len.
REFMEM_PTR_WIDTH, 20, reference memory address width.
REF_MAX, 2**REFMEM_PTR_WIDTH, largest legal ref_len in samples.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rs  in  1  start strobe (level-sampled in IDLE)
op_mode  in  1  0 = normal, 1 = load reference
ref_len  in  AXIS_WIDTH  number of samples to load
busy  out  1  high from accepted start until return to IDLE
ref_load_done  out  1  sticky, high when memory holds a complete reference
src_fifo_clear  out  1  source FIFO clear
src_fifo_rden  out  1  pop strobe (combinational)
src_fifo_empty  in  1  source FIFO empty
src_fifo_data  in  32  FWFT data; [15:0] is sample 2k, [31:16] is sample 2k+1
sink_fifo_wren  out  1  sink write strobe
sink_fifo_full  in  1  sink FIFO full
sink_fifo_data  out  32  status word
sink_fifo_last  out  1  end of status packet
ref_wren  out  1  reference memory write enable
ref_addr  out  REFMEM_PTR_WIDTH  write address
ref_wdata  out  WIDTH  write data

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except src_fifo_clear = 1. Internal count and state cleared. Reset mid-load abandons the load and leaves ref_load_done = 0.
- FIFO semantics: FWFT. Data is valid whenever empty = 0. src_fifo_rden pops exactly one word, and is never asserted while empty = 1.
- States: IDLE, LOAD, ACK.
- IDLE:
  - busy = 0, src_fifo_clear = 1.
  - Start condition: rs = 1 and op_mode = 1. On start, clear ref_load_done, reset count and half select, and latch ref_len.
  - If latched ref_len == 0 or ref_len > REF_MAX, set the error flag and go to ACK.
  - Otherwise go to LOAD.
  - With op_mode = 0, rs is ignored.
- LOAD:
  - busy = 1, src_fifo_clear = 0.
  - Each cycle with empty = 0 consumes one half-word: low half when half = 0, high half when half = 1.
  - Pop the word on its high-half cycle, or on its low-half cycle if that half is the final sample (odd ref_len; the unused upper half is discarded).
  - Registered write: ref_wren, ref_addr = count, ref_wdata = selected half, all appearing one cycle after the half is consumed. count increments by 1.
  - When empty = 1: no consume, ref_wren = 0 next cycle, state and count held.
  - After sample ref_len-1 is consumed, go to ACK.
  - rs is ignored while busy.
- ACK:
  - Wait while sink_fifo_full = 1.
  - When not full, issue one cycle of wren = 1, last = 1, data = {err, count[30:0]}.
  - Next cycle: wren = last = 0. ref_load_done <= ~err. Return to IDLE.
- Throughput: 1 sample per cycle with a non-empty FIFO. A word is popped every 2 cycles.
- Width rules:
  - count is REFMEM_PTR_WIDTH+1 bits so that REF_MAX is representable.
  - ref_addr = count[REFMEM_PTR_WIDTH-1:0], which never wraps for legal lengths.
  - ref_len is compared at full AXIS_WIDTH.
- Simultaneous events: start in the same cycle as a FIFO word arriving — the word is not consumed until LOAD.

Decomposition:
- Package dtw_pkg holds:
  - op-mode constants MODE_NORMAL / MODE_LOAD_REF;
  - the loader state enum;
  - status-word field positions (ERR_BIT = 31, count field [30:0]).
- The module is a single FSM plus datapath. No sub-module is warranted; the half-select mux is inline.

Test Plan:
1. ref_len = 4, FIFO holds 0x00020001 and 0x00040003, op_mode = 1, rs pulse → writes addr 0..3 with data 1, 2, 3, 4 on 4 consecutive cycles; 2 pops; sink word 0x00000004 with last = 1; ref_load_done = 1.
2. ref_len = 3, words 0xBBBBAAAA and 0xDDDDCCCC → writes AAAA, BBBB, CCCC at addr 0..2; 2 pops; the DDDD half is never written; status 0x00000003.
3. ref_len = 4, second word delayed 5 cycles (empty = 1) → ref_wren is low during the gap, addresses stay contiguous, no pop while empty.
4. ref_len = 0, and separately ref_len = REF_MAX+1 → no ref_wren; status 0x80000000; ref_load_done stays 0.
5. sink_fifo_full held for 6 cycles in ACK → wren is withheld, then exactly one status write; busy holds until it completes.
6. Assert rst_n = 0 after 2 of 8 samples, then restart with ref_len = 2 → outputs reset asynchronously and ref_load_done = 0; the new load writes addr 0..1 and done = 1.

Source files
------------

// File: rtl/dtw_pkg.sv
// -----------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the DTW reference-load path:
//   - op-mode encodings (normal vs. load-reference)
//   - loader FSM state encoding
//   - status-word field layout posted to the sink FIFO after a load
// No ports; imported by dtw_ref_loader.
// -----------------------------------------------------------------------------
package dtw_pkg;

    localparam logic MODE_NORMAL   = 1'b0;
    localparam logic MODE_LOAD_REF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } ld_state_e;

    // Status word: bit 31 flags a rejected length, bits 30:0 carry the
    // number of samples actually written.
    localparam int ERR_BIT     = 31;
    localparam int CNT_FIELD_W = 31;

    function automatic logic [31:0] status_word(input logic err,
                                                input logic [CNT_FIELD_W-1:0] cnt);
        return {err, cnt};
    endfunction

endpackage

// File: rtl/dtw_ref_loader.sv
// -----------------------------------------------------------------------------
// dtw_ref_loader
// Drains packed reference samples (two WIDTH-bit samples per 32-bit word)
// from the FWFT source FIFO and writes them to consecutive addresses of the
// reference memory. On completion it posts one status word to the sink FIFO
// and, if the length was legal, raises the sticky ref_load_done flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs, op_mode         start strobe (sampled in IDLE) and mode select
//   ref_len             number of samples to load
//   busy                high from accepted start until back in IDLE
//   ref_load_done       sticky "reference memory complete" flag
//   src_fifo_*          source FIFO clear / pop / empty / FWFT data
//   sink_fifo_*         status-word write / full / data / last
//   ref_wren/addr/wdata reference memory write port (registered)
// -----------------------------------------------------------------------------
module dtw_ref_loader
    import dtw_pkg::*;
#(
    parameter int          WIDTH            = 16,
    parameter int          AXIS_WIDTH       = 32,
    parameter int          REFMEM_PTR_WIDTH = 20,
    parameter int unsigned REF_MAX          = 2**REFMEM_PTR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rs,
    input  logic                        op_mode,
    input  logic [AXIS_WIDTH-1:0]       ref_len,
    output logic                        busy,
    output logic                        ref_load_done,
    output logic                        src_fifo_clear,
    output logic                        src_fifo_rden,
    input  logic                        src_fifo_empty,
    input  logic [31:0]                 src_fifo_data,
    output logic                        sink_fifo_wren,
    input  logic                        sink_fifo_full,
    output logic [31:0]                 sink_fifo_data,
    output logic                        sink_fifo_last,
    output logic                        ref_wren,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr,
    output logic [WIDTH-1:0]            ref_wdata
);

    localparam int CW = REFMEM_PTR_WIDTH + 1;  // count can hold REF_MAX itself

    // Length bound widened by one bit so REF_MAX never truncates at AXIS_WIDTH.
    localparam logic [AXIS_WIDTH:0] REF_MAX_W = (AXIS_WIDTH+1)'(REF_MAX);

    ld_state_e                   state_q, state_d;
    logic [CW-1:0]               count_q, count_d;
    logic [CW-1:0]               len_q, len_d;
    logic                        half_q, half_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic                        ref_wren_q, ref_wren_d;
    logic [REFMEM_PTR_WIDTH-1:0] ref_addr_q, ref_addr_d;
    logic [WIDTH-1:0]            ref_wdata_q, ref_wdata_d;
    logic                        sink_wren_q, sink_wren_d;
    logic                        sink_last_q, sink_last_d;
    logic [31:0]                 sink_data_q, sink_data_d;

    logic             start;
    logic             len_ok;
    logic             consume;
    logic             last_sample;
    logic [WIDTH-1:0] half_sel;

    assign start   = rs && (op_mode == MODE_LOAD_REF);
    assign len_ok  = (ref_len != '0) && ({1'b0, ref_len} <= REF_MAX_W);
    assign consume = (state_q == ST_LOAD) && !src_fifo_empty;

    // count_q is the index of the sample being consumed this cycle.
    assign last_sample = (count_q == (len_q - 1'b1));
    assign half_sel    = half_q ? src_fifo_data[2*WIDTH-1:WIDTH]
                                : src_fifo_data[WIDTH-1:0];

    // Pop after the high half, or early when the low half is the final
    // sample of an odd-length load (the upper half is then dropped).
    assign src_fifo_rden = consume && (half_q || last_sample);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        half_d      = half_q;
        err_d       = err_q;
        done_d      = done_q;
        ref_wren_d  = 1'b0;
        ref_addr_d  = ref_addr_q;
        ref_wdata_d = ref_wdata_q;
        sink_wren_d = 1'b0;
        sink_last_d = 1'b0;
        sink_data_d = sink_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    count_d = '0;
                    half_d  = 1'b0;
                    len_d   = ref_len[CW-1:0];
                    err_d   = !len_ok;
                    state_d = len_ok ? ST_LOAD : ST_ACK;
                end
            end
            ST_LOAD: begin
                if (consume) begin
                    ref_wren_d  = 1'b1;
                    ref_addr_d  = count_q[REFMEM_PTR_WIDTH-1:0];
                    ref_wdata_d = half_sel;
                    count_d     = count_q + 1'b1;
                    half_d      = !half_q;
                    if (last_sample) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (sink_wren_q) begin
                    // Status word went out last cycle; wrap up.
                    done_d  = !err_q;
                    state_d = ST_IDLE;
                end else if (!sink_fifo_full) begin
                    sink_wren_d = 1'b1;
                    sink_last_d = 1'b1;
                    sink_data_d = status_word(err_q, CNT_FIELD_W'(count_q));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            half_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            ref_wren_q  <= 1'b0;
            ref_addr_q  <= '0;
            ref_wdata_q <= '0;
            sink_wren_q <= 1'b0;
            sink_last_q <= 1'b0;
            sink_data_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            half_q      <= half_d;
            err_q       <= err_d;
            done_q      <= done_d;
            ref_wren_q  <= ref_wren_d;
            ref_addr_q  <= ref_addr_d;
            ref_wdata_q <= ref_wdata_d;
            sink_wren_q <= sink_wren_d;
            sink_last_q <= sink_last_d;
            sink_data_q <= sink_data_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign src_fifo_clear = (state_q == ST_IDLE);
    assign ref_load_done  = done_q;
    assign ref_wren       = ref_wren_q;
    assign ref_addr       = ref_addr_q;
    assign ref_wdata      = ref_wdata_q;
    assign sink_fifo_wren = sink_wren_q;
    assign sink_fifo_last = sink_last_q;
    assign sink_fifo_data = sink_data_q;

endmodule

// File: tb/tb_dtw_ref_loader.sv
// -----------------------------------------------------------------------------
// tb_dtw_ref_loader
// Scoreboard bench for dtw_ref_loader. Stimulus pushes expected memory
// writes, status words and point probes into queues; a negedge monitor
// pops and compares them as the DUT produces output.
// -----------------------------------------------------------------------------
module tb_dtw_ref_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rs;
    logic        op_mode;
    logic [31:0] ref_len;
    logic        busy;
    logic        ref_load_done;
    logic        src_fifo_clear;
    logic        src_fifo_rden;
    logic        src_fifo_empty = 1'b1;
    logic [31:0] src_fifo_data  = 32'h0;
    logic        sink_fifo_wren;
    logic        sink_fifo_full;
    logic [31:0] sink_fifo_data;
    logic        sink_fifo_last;
    logic        ref_wren;
    logic [19:0] ref_addr;
    logic [15:0] ref_wdata;

    dtw_ref_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs             (rs),
        .op_mode        (op_mode),
        .ref_len        (ref_len),
        .busy           (busy),
        .ref_load_done  (ref_load_done),
        .src_fifo_clear (src_fifo_clear),
        .src_fifo_rden  (src_fifo_rden),
        .src_fifo_empty (src_fifo_empty),
        .src_fifo_data  (src_fifo_data),
        .sink_fifo_wren (sink_fifo_wren),
        .sink_fifo_full (sink_fifo_full),
        .sink_fifo_data (sink_fifo_data),
        .sink_fifo_last (sink_fifo_last),
        .ref_wren       (ref_wren),
        .ref_addr       (ref_addr),
        .ref_wdata      (ref_wdata)
    );

    always #5 clk = ~clk;

    // ---------------- source FIFO model (FWFT) ----------------
    // Bit 32 of a pushed item is a flush marker.
    logic [32:0] push_q[$];
    logic [31:0] fifo_q[$];
    logic [32:0] fifo_item;

    always @(posedge clk) begin
        if (src_fifo_rden && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (push_q.size() > 0) begin
            fifo_item = push_q.pop_front();
            if (fifo_item[32]) fifo_q.delete();
            else               fifo_q.push_back(fifo_item[31:0]);
        end
        src_fifo_empty <= (fifo_q.size() == 0);
        src_fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end

    // ---------------- scoreboard ----------------
    localparam int PR_BUSY  = 0;
    localparam int PR_DONE  = 1;
    localparam int PR_CLEAR = 2;
    localparam int PR_WREN  = 3;
    localparam int PR_SINKW = 4;
    localparam int PR_POPS  = 5;
    localparam int PR_REFQ  = 6;
    localparam int PR_SINKQ = 7;
    localparam int PR_RDEN  = 8;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } probe_t;

    probe_t      probe_q[$];
    logic [35:0] exp_ref[$];    // {addr, data}
    logic [31:0] exp_sink[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0;

    function automatic string pname(input int k);
        case (k)
            PR_BUSY:  return "busy";
            PR_DONE:  return "ref_load_done";
            PR_CLEAR: return "src_fifo_clear";
            PR_WREN:  return "ref_wren";
            PR_SINKW: return "sink_fifo_wren";
            PR_POPS:  return "pop_count";
            PR_REFQ:  return "pending_ref_writes";
            PR_SINKQ: return "pending_status_words";
            PR_RDEN:  return "src_fifo_rden";
            default:  return "unknown";
        endcase
    endfunction

    probe_t      pr;
    logic [31:0] act;
    logic [35:0] er;
    logic [31:0] es;

    always @(negedge clk) begin
        if (src_fifo_rden) begin
            n_cmp++;
            if (src_fifo_empty) begin
                n_bad++;
                $display("FAIL rden_while_empty: rden=1 empty=%b, required empty=0", src_fifo_empty);
            end else begin
                pop_cnt++;
            end
        end
        if (ref_wren) begin
            n_cmp++;
            if (exp_ref.size() == 0) begin
                n_bad++;
                $display("FAIL ref_write: unexpected write addr=%0d data=%h, required none", ref_addr, ref_wdata);
            end else begin
                er = exp_ref.pop_front();
                if ({ref_addr, ref_wdata} !== er) begin
                    n_bad++;
                    $display("FAIL ref_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             ref_addr, ref_wdata, er[35:16], er[15:0]);
                end else begin
                    $display("ref write addr=%0d data=%h ok", ref_addr, ref_wdata);
                end
            end
        end
        if (sink_fifo_wren) begin
            n_cmp++;
            if (exp_sink.size() == 0) begin
                n_bad++;
                $display("FAIL status_word: unexpected write %h, required none", sink_fifo_data);
            end else begin
                es = exp_sink.pop_front();
                if (sink_fifo_data !== es || sink_fifo_last !== 1'b1 || sink_fifo_full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL status_word: got %h last=%b full=%b, required %h last=1 full=0",
                             sink_fifo_data, sink_fifo_last, sink_fifo_full, es);
                end else begin
                    $display("status word %h last=1 ok", sink_fifo_data);
                end
            end
        end
        while (probe_q.size() > 0) begin
            pr = probe_q.pop_front();
            case (pr.kind)
                PR_BUSY:  act = {31'h0, busy};
                PR_DONE:  act = {31'h0, ref_load_done};
                PR_CLEAR: act = {31'h0, src_fifo_clear};
                PR_WREN:  act = {31'h0, ref_wren};
                PR_SINKW: act = {31'h0, sink_fifo_wren};
                PR_POPS:  act = 32'(pop_cnt);
                PR_REFQ:  act = 32'(exp_ref.size());
                PR_SINKQ: act = 32'(exp_sink.size());
                PR_RDEN:  act = {31'h0, src_fifo_rden};
                default:  act = 32'hFFFF_FFFF;
            endcase
            n_cmp++;
            if (act !== pr.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, required %0h", pname(pr.kind), act, pr.exp);
            end
            if (pr.kind == PR_POPS) pop_cnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int k, input logic [31:0] e);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        probe_q.push_back(p);
    endtask

    task automatic push_word(input logic [31:0] w);
        push_q.push_back({1'b0, w});
    endtask

    task automatic exp_wr(input logic [19:0] a, input logic [15:0] d);
        exp_ref.push_back({a, d});
    endtask

    // rs is raised now and sampled at the next rising edge.
    task automatic start_load(input logic [31:0] len);
        op_mode = 1'b1;
        ref_len = len;
        rs      = 1'b1;
        tick();
        rs      = 1'b0;
    endtask

    task automatic finish_load(input int pops, input logic done);
        for (int i = 0; i < 200 && busy; i++) tick();
        probe(PR_BUSY, 32'd0);
        probe(PR_DONE, {31'h0, done});
        probe(PR_CLEAR, 32'd1);
        probe(PR_POPS, 32'(pops));
        probe(PR_REFQ, 32'd0);
        probe(PR_SINKQ, 32'd0);
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        rs             = 1'b0;
        op_mode        = 1'b0;
        ref_len        = 32'h0;
        sink_fifo_full = 1'b0;

        // Reset state
        #1;
        probe(PR_BUSY, 32'd0);
        probe(PR_DONE, 32'd0);
        probe(PR_CLEAR, 32'd1);
        probe(PR_WREN, 32'd0);
        probe(PR_SINKW, 32'd0);
        probe(PR_RDEN, 32'd0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: four samples, data arrives in the same cycle rs is sampled
        push_word(32'h0002_0001);
        push_word(32'h0004_0003);
        for (int i = 0; i < 4; i++) exp_wr(20'(i), 16'(i + 1));
        exp_sink.push_back(32'h0000_0004);
        tick();
        start_load(32'd4);
        probe(PR_WREN, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            probe(PR_WREN, 32'd1);
        end
        tick();
        probe(PR_WREN, 32'd0);
        finish_load(2, 1'b1);

        // op_mode = 0: rs ignored, done stays set
        op_mode = 1'b0;
        rs      = 1'b1;
        tick(); tick();
        probe(PR_BUSY, 32'd0);
        probe(PR_DONE, 32'd1);
        rs = 1'b0;
        tick();

        // 2: odd length, upper half of last word discarded
        push_word(32'hBBBB_AAAA);
        push_word(32'hDDDD_CCCC);
        exp_wr(20'd0, 16'hAAAA);
        exp_wr(20'd1, 16'hBBBB);
        exp_wr(20'd2, 16'hCCCC);
        exp_sink.push_back(32'h0000_0003);
        tick();
        start_load(32'd3);
        finish_load(2, 1'b1);

        // 3: FIFO runs dry for five cycles mid-load
        push_word(32'h0012_0011);
        exp_wr(20'd0, 16'h0011);
        exp_wr(20'd1, 16'h0012);
        exp_wr(20'd2, 16'h0013);
        exp_wr(20'd3, 16'h0014);
        exp_sink.push_back(32'h0000_0004);
        tick();
        start_load(32'd4);
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            probe(PR_WREN, 32'd0);
        end
        push_word(32'h0014_0013);
        finish_load(2, 1'b1);

        // 4: illegal lengths
        exp_sink.push_back(32'h8000_0000);
        start_load(32'd0);
        finish_load(0, 1'b0);
        exp_sink.push_back(32'h8000_0000);
        start_load(32'h0010_0001);
        finish_load(0, 1'b0);

        // 5: sink FIFO full for six cycles in ACK
        sink_fifo_full = 1'b1;
        push_word(32'h0006_0005);
        exp_wr(20'd0, 16'h0005);
        exp_wr(20'd1, 16'h0006);
        exp_sink.push_back(32'h0000_0002);
        tick();
        start_load(32'd2);
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            probe(PR_SINKW, 32'd0);
            probe(PR_BUSY, 32'd1);
        end
        sink_fifo_full = 1'b0;
        finish_load(1, 1'b1);

        // 6: async reset mid-load, then a fresh two-sample load
        push_word(32'h00A2_00A1);
        push_word(32'h00A4_00A3);
        push_word(32'h00A6_00A5);
        push_word(32'h00A8_00A7);
        exp_wr(20'd0, 16'h00A1);
        tick();
        start_load(32'd8);
        tick(); tick();
        rst_n = 1'b0;
        exp_ref.delete();   // sample 1 was written but is masked by the reset
        exp_wr(20'd0, 16'h00A1);
        void'(exp_ref.pop_front());
        #1;
        probe(PR_BUSY, 32'd0);
        probe(PR_DONE, 32'd0);
        probe(PR_CLEAR, 32'd1);
        probe(PR_WREN, 32'd0);
        probe(PR_SINKW, 32'd0);
        probe(PR_POPS, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        push_q.push_back({1'b1, 32'h0});
        push_word(32'h2222_1111);
        exp_wr(20'd0, 16'h1111);
        exp_wr(20'd1, 16'h2222);
        exp_sink.push_back(32'h0000_0002);
        tick();
        start_load(32'd2);
        finish_load(1, 1'b1);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
